// File: rtl/dst_fwd_tracker.sv
// Purpose: tracks the EX-selected write-back destination through MEM and WB and
//          derives EX operand forwarding selects and the ID load-use hazard flag.
// Latency: ex_dst -> mem_dst 1 cycle, -> wb_dst 2 cycles (stall cycles excluded);
//          fwd_a/fwd_b/load_use are combinational.
// Backpressure: stall freezes all tracking state; flush turns the entry leaving EX
//          into a bubble; stall has priority over flush.
//
// Ports:
//   clk, rst            rising-edge clock, async active-high reset (clears all state)
//   stall, flush        pipeline freeze / EX->MEM bubble insertion
//   ex_dst, ex_reg_write, ex_mem_read   destination and qualifiers of the EX instruction
//   ex_rs, ex_rt        EX source operands (forwarding compare)
//   id_rs, id_rt        ID source operands (load-use compare)
//   mem_dst, mem_reg_write, wb_dst, wb_reg_write   tracked destinations
//   fwd_a, fwd_b        00 = register file, 10 = MEM result, 01 = WB result
//   load_use            ID must stall one cycle, EX gets a bubble
//   fwd_count           (only with DST_FWD_STATS_EN) saturating count of forwarding cycles
//
// Optional feature macro: DST_FWD_STATS_EN

module dst_fwd_tracker #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [REG_ADDR_W-1:0] ex_dst,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rs,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  output logic [REG_ADDR_W-1:0] mem_dst,
  output logic                  mem_reg_write,
  output logic [REG_ADDR_W-1:0] wb_dst,
  output logic                  wb_reg_write,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  load_use
`ifdef DST_FWD_STATS_EN
  ,
  output logic [15:0]           fwd_count
`endif
);

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_WB  = 2'b01;

  // EX/MEM and MEM/WB tracking registers. Reset is asynchronous so an abort
  // drops every in-flight entry (and thus every forward) without waiting for an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_dst       <= '0;
      mem_reg_write <= 1'b0;
      wb_dst        <= '0;
      wb_reg_write  <= 1'b0;
    end else if (!stall) begin
      // WB always advances from MEM; only the EX->MEM hop sees the bubble.
      wb_dst       <= mem_dst;
      wb_reg_write <= mem_reg_write;
      if (flush) begin
        mem_dst       <= '0;
        mem_reg_write <= 1'b0;
      end else begin
        mem_dst       <= ex_dst;
        mem_reg_write <= ex_reg_write;
      end
    end
  end

  // A stage is a usable producer only if it writes and its target is not r0.
  logic mem_live;
  logic wb_live;

  assign mem_live = mem_reg_write && (mem_dst != ZERO_REG);
  assign wb_live  = wb_reg_write  && (wb_dst  != ZERO_REG);

  // MEM is checked first: it holds the younger producer, so it wins a double match.
  always_comb begin
    fwd_a = SEL_RF;
    if (mem_live && (mem_dst == ex_rs)) begin
      fwd_a = SEL_MEM;
    end else if (wb_live && (wb_dst == ex_rs)) begin
      fwd_a = SEL_WB;
    end
  end

  always_comb begin
    fwd_b = SEL_RF;
    if (mem_live && (mem_dst == ex_rt)) begin
      fwd_b = SEL_MEM;
    end else if (wb_live && (wb_dst == ex_rt)) begin
      fwd_b = SEL_WB;
    end
  end

  // Load result is not available until after MEM, so a dependent ID instruction
  // cannot be covered by forwarding next cycle. Deliberately independent of stall.
  assign load_use = ex_mem_read && ex_reg_write && (ex_dst != ZERO_REG) &&
                    ((ex_dst == id_rs) || (ex_dst == id_rt));

`ifdef DST_FWD_STATS_EN
  logic fwd_any;

  assign fwd_any = (fwd_a != SEL_RF) || (fwd_b != SEL_RF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_count <= '0;
    end else if (!stall && fwd_any && (fwd_count != 16'hFFFF)) begin
      fwd_count <= fwd_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/dst_fwd_tracker.md
Name: dst_fwd_tracker

Overview:
- Sits directly downstream of the EX-stage destination-register 3:1 select (rt / rd / 31).
- Registers the selected write-back destination and its RegWrite qualifier through the EX/MEM and MEM/WB boundaries.
- From the tracked destinations it produces:
  - forwarding selects for the two EX-stage ALU operands;
  - a load-use hazard flag for the ID stage.

Parameters:
- REG_ADDR_W, 5, width of a register address; register 0 is hard-wired zero and never forwarded.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  reset, asynchronous, active-high; clears all state.
- stall  input  1  global freeze; MEM and WB tracking registers hold their values.
- flush  input  1  turns the instruction leaving EX into a bubble at the EX/MEM boundary.
- ex_dst  input  REG_ADDR_W  destination address selected for the instruction in EX.
- ex_reg_write  input  1  EX instruction writes the register file.
- ex_mem_read  input  1  EX instruction is a load.
- ex_rs  input  REG_ADDR_W  source A of the instruction in EX.
- ex_rt  input  REG_ADDR_W  source B of the instruction in EX.
- id_rs  input  REG_ADDR_W  source A of the instruction in ID.
- id_rt  input  REG_ADDR_W  source B of the instruction in ID.
- mem_dst  output  REG_ADDR_W  destination tracked in MEM.
- mem_reg_write  output  1  MEM entry valid for write-back.
- wb_dst  output  REG_ADDR_W  destination tracked in WB; drives the register-file write address.
- wb_reg_write  output  1  register-file write enable.
- fwd_a  output  2  operand A source: 00 = register file, 10 = MEM result, 01 = WB result.
- fwd_b  output  2  operand B source, same encoding as fwd_a.
- load_use  output  1  ID must stall one cycle and EX must receive a bubble.

Behaviour:

Reset:
- mem_dst, wb_dst = 0; mem_reg_write, wb_reg_write = 0.
- Consequently fwd_a = fwd_b = 00 and load_use = 0 for as long as rst is high.
- Asserting rst mid-operation discards all in-flight entries immediately; it does not wait for a clock edge.

Register update on each rising clk edge, when rst is low:
- If stall = 1: all four tracking registers hold. flush is ignored that cycle (stall has priority); upstream re-asserts flush after the stall releases.
- Else if flush = 1: mem_dst <= 0, mem_reg_write <= 0, and WB <= previous MEM contents.
- Else: mem_dst <= ex_dst, mem_reg_write <= ex_reg_write, wb_dst <= mem_dst, wb_reg_write <= mem_reg_write.
- An entry with ex_reg_write = 0 is captured with its reg_write bit cleared. Its destination value is don't-care but still registered.

Forwarding (combinational from registered state plus EX sources):
- fwd_a = 10 when mem_reg_write and mem_dst != 0 and mem_dst == ex_rs.
- Otherwise fwd_a = 01 when wb_reg_write and wb_dst != 0 and wb_dst == ex_rs.
- Otherwise fwd_a = 00.
- fwd_b is identical, using ex_rt.
- When MEM and WB both match, MEM wins (youngest producer).
- Encoding 11 is never driven.

Load-use (combinational):
- load_use = ex_mem_read and ex_reg_write and ex_dst != 0 and (ex_dst == id_rs or ex_dst == id_rt).
- load_use is asserted independently of stall.

Latency:
- An ex_dst value appears on mem_dst 1 cycle later and on wb_dst 2 cycles later, excluding stall cycles.

Optional Feature:
- Macro: DST_FWD_STATS_EN.
- Defined:
  - Adds output fwd_count (16 bits): a saturating counter of cycles in which fwd_a != 00 or fwd_b != 00, counting once per cycle.
  - Counts only when stall = 0 and rst = 0.
  - Resets asynchronously to 0.
  - Holds at 16'hFFFF once reached.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset mid-stream: with mem_reg_write = 1 and mem_dst = 8, assert rst between edges -> mem_reg_write, wb_reg_write, fwd_a, fwd_b go to 0 immediately, without waiting for a clock edge.
- Back-to-back dependency: cycle 0 ex_dst = 9, ex_reg_write = 1; cycle 1 ex_rs = 9 -> fwd_a = 10. Cycle 2 ex_rt = 9 -> fwd_b = 01. Cycle 3 -> fwd_b = 00.
- Double match: MEM and WB both hold dst = 5 with reg_write = 1; ex_rs = ex_rt = 5 -> fwd_a = fwd_b = 10.
- Zero register: ex_dst = 0 with ex_reg_write = 1, then ex_rs = 0 -> fwd_a = 00 in both following cycles.
- Load-use: ex_mem_read = 1, ex_reg_write = 1, ex_dst = 12, id_rt = 12 -> load_use = 1. Same with ex_dst = 0 -> load_use = 0.
- Stall/flush interaction: MEM holds dst = 3 valid; assert stall and flush together for 2 cycles -> mem_dst stays 3, wb unchanged. Release stall with flush = 1 -> mem_reg_write = 0 and wb_dst = 3, wb_reg_write = 1 after the edge.
